// File: rtl/ahb_sram_subordinate.sv
// ---------------------------------------------------------------------------
// ahb_sram_subordinate
//
// AHB-Lite subordinate that fronts an internal array of DEPTH_WORDS 32-bit
// words. Each OKAY data phase is stretched by WAIT_STATES low cycles of
// HREADYOUT. Misaligned, oversized or out-of-range transfers get the
// two-cycle ERROR response and never touch the array.
//
// Ports
//   CLK        clock, rising edge
//   nRST       asynchronous active-low reset
//   HSEL       subordinate select
//   HADDR      byte address (address phase)
//   HTRANS     IDLE/BUSY/NONSEQ/SEQ (address phase)
//   HWRITE     1 = write (address phase)
//   HSIZE      0 = byte, 1 = half, 2 = word (address phase)
//   HWDATA     write data (data phase)
//   HREADY     bus ready, previous transfer finished
//   HREADYOUT  this subordinate's data phase is done
//   HRESP      0 = OKAY, 1 = ERROR
//   HRDATA     read data; zero outside a completing read
// ---------------------------------------------------------------------------
module ahb_sram_subordinate #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  typedef logic [1:0]  htrans_t;
  typedef logic [31:0] word_t;

  localparam htrans_t HTRANS_NONSEQ = 2'b10;
  localparam htrans_t HTRANS_SEQ    = 2'b11;

  localparam int          AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L     = 32'(DEPTH_WORDS);
  localparam int          WAIT_LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]  WAIT_LOAD   = 4'(WAIT_LOAD_I);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] word_q, word_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          write_q, write_d;
  logic          pend_q, pend_d;

  word_t mem [DEPTH_WORDS];

  logic       xferValid;
  logic       reqErr;
  logic       dataDone;
  logic [3:0] laneEn;

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  // New address phases are only taken while our own data phase is finishing
  // (IDLE or ERR2), so a bus that raises HREADY early cannot corrupt a
  // transfer still in WAIT or ERR1.
  assign xferValid = HSEL && HREADY && HREADYOUT &&
                     ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  assign reqErr = (HSIZE > 3'd2) ||
                  ((HSIZE == 3'd1) && HADDR[0]) ||
                  ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) ||
                  ({2'b00, HADDR[31:2]} >= DEPTH_L);

  // pend_q marks an accepted OKAY transfer; its data phase completes in the
  // first IDLE cycle, which is where writes commit and reads return data.
  assign dataDone = (state_q == ST_IDLE) && pend_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    pend_d  = pend_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
        if (xferValid) begin
          word_d  = HADDR[AW+1:2];
          off_d   = HADDR[1:0];
          size_d  = HSIZE[1:0];
          write_d = HWRITE;
          if (reqErr) begin
            state_d = ST_ERR1;
          end else begin
            pend_d = 1'b1;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_LOAD;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      word_q  <= '0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      write_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
      pend_q  <= pend_d;
    end
  end

  // Little-endian lane selection; halfwords are already known to sit at
  // offset 0 or 2 because misaligned ones were turned into errors.
  always_comb begin
    laneEn = 4'b0000;
    case (size_q)
      2'd0:    laneEn = 4'b0001 << off_q;
      2'd1:    laneEn = off_q[1] ? 4'b1100 : 4'b0011;
      default: laneEn = 4'b1111;
    endcase
  end

  // The array has no reset; an aborted transfer never reaches dataDone.
  always_ff @(posedge CLK) begin
    if (dataDone && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (laneEn[i]) begin
          mem[word_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // A write commits on the edge before a following read's data phase, so
  // reading the array directly already returns the fresh word.
  always_comb begin
    HRDATA = '0;
    if (dataDone && !write_q) begin
      HRDATA = mem[word_q];
    end
  end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_subordinate
//
// Three instances of ahb_sram_subordinate (WAIT_STATES 1, 0 and 3) share one
// clock and reset. A pipelined bus driver issues transfers; on issue the
// reference model (a plain word array plus the alignment/range rules) pushes
// the expected data-phase response into a queue. Per-instance monitors watch
// the bus, pop an expectation whenever an address phase is taken, and compare
// the wait count, response and read data when the data phase completes.
// ---------------------------------------------------------------------------
module tb_ahb_sram_subordinate;

  localparam int NDUT  = 3;
  localparam int DEPTH = 64;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xferT;

  typedef struct {
    bit          isErr;
    int          waits;
    logic [31:0] rdata;
    bit          abort;
  } expT;

  logic clk = 1'b0;
  logic nrst = 1'b0;

  logic [NDUT-1:0] hsel, hwrite, hready, hreadyout, hresp;
  logic [31:0]     haddr  [NDUT];
  logic [1:0]      htrans [NDUT];
  logic [2:0]      hsize  [NDUT];
  logic [31:0]     hwdata [NDUT];
  logic [31:0]     hrdata [NDUT];

  xferT        stimQ[$];
  expT         expQ[$];
  logic [31:0] model [NDUT][DEPTH];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    assign hready[g] = hreadyout[g];
    ahb_sram_subordinate #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES(WS)
    ) dut (
      .CLK      (clk),
      .nRST     (nrst),
      .HSEL     (hsel[g]),
      .HADDR    (haddr[g]),
      .HTRANS   (htrans[g]),
      .HWRITE   (hwrite[g]),
      .HSIZE    (hsize[g]),
      .HWDATA   (hwdata[g]),
      .HREADY   (hready[g]),
      .HREADYOUT(hreadyout[g]),
      .HRESP    (hresp[g]),
      .HRDATA   (hrdata[g])
    );
  end

  function automatic int waitsOf(int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic checkOutput(string name, logic [63:0] got, logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  function automatic xferT mk(bit sel, logic [1:0] trans, bit write,
                              logic [2:0] size, logic [31:0] addr, logic [31:0] wdata);
    xferT t;
    t.sel   = sel;
    t.trans = trans;
    t.write = write;
    t.size  = size;
    t.addr  = addr;
    t.wdata = wdata;
    return t;
  endfunction

  // Error rule: size beyond a word, address not a multiple of the transfer
  // size, or word index beyond the array.
  function automatic bit refIsError(logic [2:0] size, logic [31:0] addr);
    int unsigned nb;
    if (size > 3'd2) return 1'b1;
    nb = 32'd1 << size;
    if ((addr % nb) != 0) return 1'b1;
    if ((addr / 4) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void modelIssue(int d, xferT t);
    expT         e;
    int          idx;
    int          nb;
    int          b;
    logic [31:0] w;
    if (!(t.sel && (t.trans == T_NONSEQ || t.trans == T_SEQ))) return;
    e.abort = 1'b0;
    e.rdata = 32'h0;
    if (refIsError(t.size, t.addr)) begin
      e.isErr = 1'b1;
      e.waits = 1;
    end else begin
      e.isErr = 1'b0;
      e.waits = waitsOf(d);
      idx = int'(t.addr / 4);
      w = model[d][idx];
      if (t.write) begin
        nb = 1 << t.size;
        for (int k = 0; k < nb; k++) begin
          b = int'(t.addr % 4) + k;
          w[8*b +: 8] = t.wdata[8*b +: 8];
        end
        model[d][idx] = w;
      end else begin
        e.rdata = w;
      end
    end
    expQ.push_back(e);
  endfunction

  function automatic xferT randXfer();
    xferT        t;
    int          pick;
    int unsigned nb;
    pick    = $urandom_range(0, 9);
    t.sel   = ($urandom_range(0, 7) != 0);
    t.trans = (pick < 2) ? T_IDLE : ((pick < 3) ? T_BUSY : ((pick < 7) ? T_NONSEQ : T_SEQ));
    t.write = 1'($urandom_range(0, 1));
    t.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    pick    = $urandom_range(0, 19);
    if (pick == 0) begin
      t.addr = 32'($urandom_range(DEPTH * 4, DEPTH * 4 + 255));
    end else if (pick == 1) begin
      t.addr = {1'b1, 31'($urandom())};
    end else begin
      t.addr = 32'($urandom_range(0, DEPTH * 4 - 1));
      if (pick > 3 && t.size <= 3'd2) begin
        nb = 32'd1 << t.size;
        t.addr = (t.addr / nb) * nb;
      end
    end
    t.wdata = $urandom();
    return t;
  endfunction

  task automatic driveAddr(int d, xferT t);
    hsel[d]   = t.sel;
    htrans[d] = t.trans;
    hwrite[d] = t.write;
    hsize[d]  = t.size;
    haddr[d]  = t.addr;
  endtask

  // Holds the current address phase until an edge with HREADY high. HWDATA
  // carries junk until the cycle that completes the data phase.
  task automatic stepUntilReady(int d, logic [31:0] wdata);
    int guard;
    bit rdy;
    guard = 0;
    rdy = 1'b0;
    hwdata[d] = $urandom();
    while (!rdy) begin
      @(negedge clk);
      rdy = hready[d];
      if (rdy) hwdata[d] = wdata;
      @(posedge clk);
      #1;
      if (!rdy) begin
        guard++;
        if (guard > 40) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL hready timeout dut%0d: HREADY low for %0d cycles, expected at most 15", d, guard);
          rdy = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(int d);
    xferT        t;
    logic [31:0] dataPhaseW;
    dataPhaseW = 32'h0;
    while (stimQ.size() > 0) begin
      t = stimQ.pop_front();
      driveAddr(d, t);
      modelIssue(d, t);
      stepUntilReady(d, dataPhaseW);
      dataPhaseW = t.wdata;
    end
    driveAddr(d, mk(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0));
    stepUntilReady(d, dataPhaseW);
    stepUntilReady(d, 32'h0);
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_mon
    bit  active = 1'b0;
    int  lowCycles = 0;
    int  respOnes = 0;
    int  respZeros = 0;
    bit  earlyData = 1'b0;
    int  respCode;
    expT cur;
    initial begin
      forever begin
        @(negedge clk);
        if (!nrst) active = 1'b0;
        if (!active) begin
          checkOutput($sformatf("idle phase dut%0d", g),
                      64'({hreadyout[g], hresp[g], hrdata[g]}), 64'({1'b1, 1'b0, 32'h0}));
        end else begin
          if (hresp[g]) respOnes++;
          else          respZeros++;
          if (!hreadyout[g]) begin
            lowCycles++;
            if (hrdata[g] !== 32'h0) earlyData = 1'b1;
            if (lowCycles > 40) begin
              compared++;
              mismatched++;
              $display("[TB] FAIL stall dut%0d: %0d low cycles, expected %0d", g, lowCycles, cur.waits);
              active = 1'b0;
            end
          end else begin
            respCode = (respZeros == 0) ? 1 : ((respOnes == 0) ? 0 : 2);
            checkOutput($sformatf("wait cycles dut%0d", g), 64'(lowCycles), 64'(cur.waits));
            checkOutput($sformatf("hresp dut%0d", g), 64'(respCode), 64'(cur.isErr));
            checkOutput($sformatf("hrdata dut%0d", g), 64'(hrdata[g]), 64'(cur.rdata));
            checkOutput($sformatf("hrdata in wait dut%0d", g), 64'(earlyData), 64'(0));
            active = 1'b0;
          end
        end
        if (nrst && hreadyout[g] && hsel[g] && (htrans[g] == T_NONSEQ || htrans[g] == T_SEQ)) begin
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard dut%0d: transfer taken with no expectation queued", g);
          end else begin
            cur       = expQ.pop_front();
            active    = 1'b1;
            lowCycles = 0;
            respOnes  = 0;
            respZeros = 0;
            earlyData = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      driveAddr(d, mk(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0));
      hwdata[d] = 32'h0;
    end
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("reset outputs dut%0d", d),
                  64'({hreadyout[d], hresp[d], hrdata[d]}), 64'({1'b1, 1'b0, 32'h0}));
    end
    #2 nrst = 1'b1;
    @(posedge clk);
    #1;

    // Give every word a known value so later reads are well defined.
    for (int d = 0; d < NDUT; d++) begin
      for (int w = 0; w < DEPTH; w++) begin
        stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'(w * 4), $urandom()));
      end
      applyStimulus(d);
    end

    $display("[TB] directed one-wait-state sequence");
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'h11223344));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b1, 3'd0, 32'h13, 32'hAA000000));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h2, 32'h0));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h0, 32'h0));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'(DEPTH * 4), 32'h0));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b1, 3'd3, 32'h4, 32'hFFFFFFFF));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'(DEPTH * 4), 32'h55555555));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b1, 3'd1, 32'h1, 32'h77777777));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h0, 32'h0));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h4, 32'h0));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b1, 3'd1, 32'h2, 32'hBEEF0000));
    stimQ.push_back(mk(1'b1, T_SEQ,    1'b0, 3'd2, 32'h0, 32'h0));
    applyStimulus(0);

    $display("[TB] directed zero-wait-state sequence");
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h40, 32'h0));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h44, 32'h0BADF00D));
    stimQ.push_back(mk(1'b1, T_IDLE,   1'b1, 3'd2, 32'h40, 32'h11111111));
    stimQ.push_back(mk(1'b1, T_BUSY,   1'b1, 3'd2, 32'h40, 32'h22222222));
    stimQ.push_back(mk(1'b0, T_NONSEQ, 1'b1, 3'd2, 32'h40, 32'h33333333));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h40, 32'h0));
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b1, 3'd1, 32'h46, 32'hBEEF0000));
    stimQ.push_back(mk(1'b1, T_SEQ,    1'b1, 3'd0, 32'h41, 32'h00005A00));
    stimQ.push_back(mk(1'b1, T_SEQ,    1'b0, 3'd2, 32'h44, 32'h0));
    stimQ.push_back(mk(1'b1, T_SEQ,    1'b0, 3'd2, 32'h40, 32'h0));
    applyStimulus(1);

    $display("[TB] randomized traffic");
    for (int d = 0; d < NDUT; d++) begin
      repeat (80) stimQ.push_back(randXfer());
      applyStimulus(d);
    end

    $display("[TB] reset during a wait state");
    driveAddr(0, mk(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h20, 32'h12345678));
    expQ.push_back('{isErr: 1'b0, waits: 1, rdata: 32'h0, abort: 1'b1});
    @(negedge clk);
    @(posedge clk);
    #1;
    driveAddr(0, mk(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0));
    hwdata[0] = 32'h12345678;
    checkOutput("in wait before reset", 64'(hreadyout[0]), 64'(0));
    #2 nrst = 1'b0;
    #1;
    checkOutput("outputs on reset assert",
                64'({hreadyout[0], hresp[0], hrdata[0]}), 64'({1'b1, 1'b0, 32'h0}));
    repeat (2) @(posedge clk);
    #3 nrst = 1'b1;
    @(posedge clk);
    #1;
    stimQ.push_back(mk(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h0));
    applyStimulus(0);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("expectations drained", 64'(expQ.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ahb_sram_subordinate.md
AHB_SRAM_SUBORDINATE -- requirements
Module: ahb_sram_subordinate

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit words in the internal array.
REQ-003 Parameter WAIT_STATES, default 1, SHALL set the HREADYOUT-low cycles per OKAY read/write data phase (range 0..15).
REQ-004 The block SHALL have the following ports, in this order:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- HSEL  in  1  subordinate select
- HADDR  in  32  byte address, address phase
- HTRANS  in  2  htrans_t, address phase
- HWRITE  in  1  1=write, address phase
- HSIZE  in  3  0=byte, 1=half, 2=word, address phase
- HWDATA  in  32  write data, data phase
- HREADY  in  1  bus ready (previous transfer done)
- HREADYOUT  out  1  this subordinate's data phase done
- HRESP  out  1  0=OKAY, 1=ERROR
- HRDATA  out  32  read data, word_t

Function
REQ-005 An address phase SHALL be accepted on a rising edge only when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ.
REQ-006 On acceptance the block SHALL register HADDR, HWRITE and HSIZE for the data phase.
REQ-007 HSEL=0, HTRANS=IDLE or HTRANS=BUSY with HREADY=1 SHALL produce a zero-wait OKAY data phase (HREADYOUT=1, HRESP=0) with no memory access.
REQ-008 An accepted transfer SHALL be flagged as an error if any of the following holds:
- HSIZE>2
- HSIZE=1 and HADDR[0]=1
- HSIZE=2 and HADDR[1:0]!=0
- HADDR[31:2] >= DEPTH_WORDS
REQ-009 The FSM SHALL have states IDLE, WAIT, ERR1 and ERR2.
REQ-010 IDLE: HREADYOUT=1, HRESP=0.
REQ-011 On accepting a valid transfer, the FSM SHALL go to WAIT if WAIT_STATES>0 and otherwise stay in IDLE as a zero-wait data phase.
REQ-012 On accepting an error transfer, the FSM SHALL go to ERR1.
REQ-013 WAIT: HREADYOUT=0 and HRESP=0, with a 4-bit counter loaded with WAIT_STATES-1 at acceptance and decremented each cycle.
REQ-014 When the WAIT counter is 0, the FSM SHALL go to IDLE, whose first cycle completes the data phase with HREADYOUT=1.
REQ-015 ERR1 SHALL drive HREADYOUT=0, HRESP=1, then go to ERR2.
REQ-016 ERR2 SHALL drive HREADYOUT=1, HRESP=1, then go to IDLE.
REQ-017 Error transfers SHALL ignore WAIT_STATES and always take exactly two cycles.
REQ-018 A new address phase SHALL be acceptable in the final data-phase cycle (IDLE completion or ERR2), giving back-to-back pipelining.
REQ-019 A write SHALL commit to the array on the rising edge that ends its data phase (HREADYOUT=1), using the HWDATA present in that cycle.
REQ-020 Byte lanes SHALL be little-endian: byte at address offset k uses HWDATA[8k+7:8k].
REQ-021 HSIZE=0 SHALL write 1 lane, HSIZE=1 SHALL write 2 lanes (offset 0 or 2), and HSIZE=2 SHALL write all 4 lanes; unselected lanes SHALL be unchanged.
REQ-022 For reads, HRDATA SHALL carry the full addressed word, combinationally from the array at the registered word address, during the completing cycle.
REQ-023 HRDATA SHALL be 0 in all other cycles.
REQ-024 Error transfers SHALL neither write the array nor return data (HRDATA=0).
REQ-025 A read directly following a write to the same word SHALL return the newly written data, with no stall.
REQ-026 HWDATA during WAIT cycles SHALL be ignored; only the completing cycle's value is used.

Reset
REQ-027 While nRST=0, outputs SHALL be HREADYOUT=1, HRESP=0, HRDATA=0; the FSM SHALL be IDLE and the counter 0.
REQ-028 Array contents SHALL not be reset.
REQ-029 Reset asserted mid data phase SHALL abort the transfer: no array write, and no pending data phase after release.

Verification
REQ-030 WAIT_STATES=1: word write 0xDEADBEEF to 0x10, then word read 0x10 -> each data phase has HREADYOUT low 1 cycle; read HRDATA=0xDEADBEEF.
REQ-031 Byte write 0xAA at 0x13 (HWDATA=0xAA000000) over word 0x11223344 -> read 0x10 returns 0xAA223344.
REQ-032 Word read at 0x2 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); array unchanged.
REQ-033 Access at HADDR=DEPTH_WORDS*4 -> two-cycle ERROR; HSIZE=3 -> two-cycle ERROR.
REQ-034 WAIT_STATES=0: back-to-back NONSEQ write/read/write -> HREADYOUT constantly 1; correct data; IDLE/BUSY interleaved give OKAY with no access.
REQ-035 nRST pulsed low during WAIT of a word write of 0x12345678 to 0x20 -> HREADYOUT=1 immediately; word 0x20 keeps its previous value.
